// File: rtl/nios_uart_pio_in.sv
// nios_uart_pio_in: Avalon-MM input PIO. Two-flop synchronizer, sticky edge
// capture (write-1-to-clear) and a maskable interrupt; reads are registered, latency 1.
module nios_uart_pio_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_MODE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_sel_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      read_val;
    logic             rd_en;
    logic             wr_en;
    logic             unused_wdata;
    reg_sel_e         reg_sel;

    assign reg_sel      = reg_sel_e'(address);
    assign rd_en        = chipselect & ~read_n;
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync2 & ~prev;
            1:       edge_det = ~sync2 & prev;
            default: edge_det = sync2 ^ prev;
        endcase
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && reg_sel == REG_EDGE)
            clr_bits = writedata[WIDTH-1:0];
    end

    always_comb begin
        read_val = '0;
        case (reg_sel)
            REG_DATA: read_val[WIDTH-1:0] = sync2;
            REG_MASK: read_val[WIDTH-1:0] = irq_mask;
            REG_EDGE: read_val[WIDTH-1:0] = edge_cap;
            default:  read_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A new edge is OR-ed in after the clear so it wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && reg_sel == REG_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~clr_bits) | edge_det;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_en ? read_val : '0;
            if (IRQ_MODE == 2)
                irq <= |(edge_cap & irq_mask);
            else if (IRQ_MODE == 1)
                irq <= |(sync2 & irq_mask);
            else
                irq <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nios_uart_pio_in.sv
// Bench for nios_uart_pio_in: three instances (rising/edge-irq, falling/level-irq,
// any-edge/no-irq) share one bus; expectations come from transition rules on the input sequence.
module tb_nios_uart_pio_in;
    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int passed = 0;
    int total  = 0;

    nios_uart_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MODE(2)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd0), .irq(irq0));

    nios_uart_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_MODE(1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd1), .irq(irq1));

    nios_uart_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MODE(0)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] r0,
                            output logic [31:0] r1, output logic [31:0] r2);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1; address = '0;
        r0 = rd0; r1 = rd1; r2 = rd2;
    endtask

    task automatic settle_and_clear();
        in_port = 8'h00;
        repeat (4) tick();
        bus_write(2'd3, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset();
        logic [31:0] r0, r1, r2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_port = 8'($urandom);
            tick();
        end
        total++; if ({rd0, rd1, rd2} !== 96'h0) $display("FAIL reset_readdata actual=%h/%h/%h required=0", rd0, rd1, rd2); else passed++;
        total++; if ({irq0, irq1, irq2} !== 3'b000) $display("FAIL reset_irq actual=%b%b%b required=000", irq0, irq1, irq2); else passed++;
        in_port = 8'h00;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        bus_read(2'd2, r0, r1, r2);
        total++; if (r0 !== 32'h0) $display("FAIL reset_irqmask actual=%h required=0", r0); else passed++;
        bus_read(2'd3, r0, r1, r2);
        total++; if ({r0, r1, r2} !== 96'h0) $display("FAIL reset_edgecap actual=%h/%h/%h required=0", r0, r1, r2); else passed++;
        total++; if (irq0 !== 1'b0) $display("FAIL reset_irq_after actual=%b required=0", irq0); else passed++;
    endtask

    task automatic test_data_path();
        logic [31:0] r0, r1, r2;
        in_port = 8'hA5;
        repeat (3) tick();
        address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
        total++; if (rd0 !== 32'h0) $display("FAIL data_before_strobe actual=%h required=0", rd0); else passed++;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        total++; if (rd0 !== 32'h0000_00A5) $display("FAIL data_read actual=%h required=000000a5", rd0); else passed++;
        total++; if (rd1 !== 32'h0000_00A5 || rd2 !== 32'h0000_00A5) $display("FAIL data_read_others actual=%h/%h required=000000a5", rd1, rd2); else passed++;
        tick();
        total++; if (rd0 !== 32'h0) $display("FAIL data_idle_zero actual=%h required=0", rd0); else passed++;
        bus_read(2'd1, r0, r1, r2);
        total++; if (r0 !== 32'h0) $display("FAIL reserved_read actual=%h required=0", r0); else passed++;
    endtask

    task automatic test_rising_capture();
        logic [31:0] r0, r1, r2;
        settle_and_clear();
        bus_write(2'd2, 32'h01);
        repeat (2) tick();
        in_port = 8'h01;
        tick();
        tick();
        total++; if (irq0 !== 1'b0 || irq1 !== 1'b0) $display("FAIL irq_k1 actual=%b%b required=00", irq0, irq1); else passed++;
        tick();
        total++; if (irq0 !== 1'b0) $display("FAIL edge_irq_k2 actual=%b required=0", irq0); else passed++;
        total++; if (irq1 !== 1'b1) $display("FAIL level_irq_k2 actual=%b required=1", irq1); else passed++;
        tick();
        total++; if (irq0 !== 1'b1) $display("FAIL edge_irq_k3 actual=%b required=1", irq0); else passed++;
        bus_read(2'd3, r0, r1, r2);
        total++; if ({r0, r1, r2} !== {32'h1, 32'h0, 32'h1}) $display("FAIL capture_rise actual=%h/%h/%h required=1/0/1", r0, r1, r2); else passed++;
        in_port = 8'h00;
        repeat (4) tick();
        bus_read(2'd3, r0, r1, r2);
        total++; if ({r0, r1, r2} !== {32'h1, 32'h1, 32'h1}) $display("FAIL capture_fall actual=%h/%h/%h required=1/1/1", r0, r1, r2); else passed++;
        bus_write(2'd3, 32'h01);
        total++; if (irq0 !== 1'b1) $display("FAIL irq_clear_n1 actual=%b required=1", irq0); else passed++;
        tick();
        total++; if (irq0 !== 1'b0) $display("FAIL irq_clear_n2 actual=%b required=0", irq0); else passed++;
    endtask

    task automatic test_w1c();
        logic [31:0] r0, r1, r2;
        settle_and_clear();
        in_port = 8'h09;
        repeat (4) tick();
        bus_read(2'd3, r0, r1, r2);
        total++; if (r0 !== 32'h09) $display("FAIL w1c_set actual=%h required=09", r0); else passed++;
        bus_write(2'd3, 32'h08);
        bus_read(2'd3, r0, r1, r2);
        total++; if (r0 !== 32'h01) $display("FAIL w1c_partial actual=%h required=01", r0); else passed++;
        bus_write(2'd3, 32'h00);
        bus_read(2'd3, r0, r1, r2);
        total++; if (r0 !== 32'h01) $display("FAIL w1c_zero actual=%h required=01", r0); else passed++;
        address = 2'd3; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; writedata = 32'hFFFF_FFFF;
        tick();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = '0;
        total++; if (rd0 !== 32'h01) $display("FAIL rw_preclear actual=%h required=01", rd0); else passed++;
        bus_read(2'd3, r0, r1, r2);
        total++; if (r0 !== 32'h0) $display("FAIL rw_cleared actual=%h required=0", r0); else passed++;
    endtask

    task automatic test_collision();
        logic [31:0] r0, r1, r2;
        settle_and_clear();
        in_port = 8'h04;
        tick();
        tick();
        bus_write(2'd3, 32'h04);
        bus_read(2'd3, r0, r1, r2);
        total++; if (r0 !== 32'h04) $display("FAIL collision_rise actual=%h required=04", r0); else passed++;
        total++; if (r2 !== 32'h04) $display("FAIL collision_any actual=%h required=04", r2); else passed++;
    endtask

    task automatic test_level_mode();
        settle_and_clear();
        bus_write(2'd2, 32'h80);
        repeat (2) tick();
        in_port = 8'h80;
        tick();
        tick();
        total++; if (irq1 !== 1'b0) $display("FAIL level_rise_k1 actual=%b required=0", irq1); else passed++;
        tick();
        total++; if (irq1 !== 1'b1) $display("FAIL level_rise_k2 actual=%b required=1", irq1); else passed++;
        in_port = 8'h00;
        tick();
        tick();
        total++; if (irq1 !== 1'b1) $display("FAIL level_fall_k1 actual=%b required=1", irq1); else passed++;
        tick();
        total++; if (irq1 !== 1'b0) $display("FAIL level_fall_k2 actual=%b required=0", irq1); else passed++;
        bus_write(2'd2, 32'h00);
        in_port = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (irq1 !== 1'b0) $display("FAIL level_masked cycle=%0d actual=%b required=0", i, irq1); else passed++;
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r0, r1, r2;
        settle_and_clear();
        bus_write(2'd2, 32'h01);
        in_port = 8'h01;
        repeat (5) tick();
        total++; if (irq0 !== 1'b1 || irq1 !== 1'b1) $display("FAIL midop_pre_irq actual=%b%b required=11", irq0, irq1); else passed++;
        #3;
        reset = 1'b1;
        #1;
        total++; if (irq0 !== 1'b0 || irq1 !== 1'b0) $display("FAIL midop_async_irq actual=%b%b required=00", irq0, irq1); else passed++;
        tick();
        reset = 1'b0;
        bus_read(2'd2, r0, r1, r2);
        total++; if (r0 !== 32'h0) $display("FAIL midop_mask actual=%h required=0", r0); else passed++;
        repeat (4) tick();
        bus_read(2'd3, r0, r1, r2);
        total++; if ({r0, r1, r2} !== {32'h1, 32'h0, 32'h1}) $display("FAIL release_high_edge actual=%h/%h/%h required=1/0/1", r0, r1, r2); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] r0, r1, r2;
        logic [7:0]  m, v, last, exp_rise, exp_fall, exp_any;
        for (int it = 0; it < 16; it++) begin
            settle_and_clear();
            m = 8'($urandom);
            bus_write(2'd2, {24'h0, m});
            last = 8'h00;
            exp_rise = '0; exp_fall = '0; exp_any = '0;
            for (int s = 0; s < int'($urandom_range(1, 6)); s++) begin
                v = 8'($urandom);
                exp_rise |= v & ~last;
                exp_fall |= ~v & last;
                exp_any  |= v ^ last;
                last = v;
                in_port = v;
                repeat ($urandom_range(1, 3)) tick();
            end
            repeat (4) tick();
            bus_read(2'd3, r0, r1, r2);
            total++; if ({r0, r1, r2} !== {24'h0, exp_rise, 24'h0, exp_fall, 24'h0, exp_any})
                $display("FAIL rand_edgecap it=%0d actual=%h/%h/%h required=%h/%h/%h", it, r0, r1, r2, exp_rise, exp_fall, exp_any); else passed++;
            bus_read(2'd0, r0, r1, r2);
            total++; if (r0 !== {24'h0, last}) $display("FAIL rand_data it=%0d actual=%h required=%h", it, r0, last); else passed++;
            total++; if ({irq0, irq1, irq2} !== {|(exp_rise & m), |(last & m), 1'b0})
                $display("FAIL rand_irq it=%0d actual=%b%b%b required=%b%b0", it, irq0, irq1, irq2, |(exp_rise & m), |(last & m)); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = '0;
        test_reset();
        test_data_path();
        test_rising_capture();
        test_w1c();
        test_collision();
        test_level_mode();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
